// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential shift-subtract divider:
// controller state encoding and the default operand width.
package divisor_seq_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice this.
    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHK  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/divisor_seq_subcmp.sv
// Combinational compare-and-subtract slice for one restoring division step.
// Works at N+1 bits so a partial remainder with its top bit set still
// compares correctly against the N-bit divisor.
module divisor_seq_subcmp #(
    parameter int N = 4
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] dr,
    output logic         ge,
    output logic [N:0]   diff
);

    assign ge   = (rem >= {1'b0, dr});
    assign diff = rem - {1'b0, dr};

endmodule

// File: rtl/divisor_seq.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor, one
// shift-compare-subtract step per clock, St/Idle/Done handshake.
// Optional macro DIVISOR_SEQ_DIVZERO_EN adds a DivZero output that reports
// a zero divisor separately from Overflow.
module divisor_seq
    import divisor_seq_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           St,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quociente,
    output logic [N-1:0]   Resto,
    output logic           Overflow,
`ifdef DIVISOR_SEQ_DIVZERO_EN
    output logic           DivZero,
`endif
    output logic           Idle,
    output logic           Done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nxt;
    logic [2*N:0]   acc;        // {partial remainder, dividend/quotient bits}
    logic [2*N:0]   shifted;
    logic [2*N:0]   acc_step;
    logic [N-1:0]   dr;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           ge;
    logic [N:0]     diff;
    logic           dr_zero;
    logic           chk_abort;  // CHK finds no valid N-bit quotient
    logic           ovf_set;    // value Overflow takes on an abort

    // Upper half >= divisor means the quotient needs more than N bits.
    assign dr_zero   = (dr == '0);
    assign chk_abort = dr_zero || (acc[2*N-1:N] >= dr);
`ifdef DIVISOR_SEQ_DIVZERO_EN
    assign ovf_set   = !dr_zero;
`else
    assign ovf_set   = 1'b1;
`endif

    // One restoring step: shift left, subtract when the window covers DR.
    assign shifted  = acc << 1;
    assign acc_step = ge ? {diff, shifted[N-1:1], 1'b1} : shifted;
    assign last     = (cnt == CW'(N - 1));

    divisor_seq_subcmp #(.N(N)) u_subcmp (
        .rem  (shifted[2*N:N]),
        .dr   (dr),
        .ge   (ge),
        .diff (diff)
    );

    // Moore status outputs.
    assign Idle = (state == IDLE);
    assign Done = (state == DONE);

    // Controller state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; St only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (St) state_nxt = CHK;
            CHK:  state_nxt = chk_abort ? DONE : STEP;
            STEP: if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, stepping, and result registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc       <= '0;
            dr        <= '0;
            cnt       <= '0;
            Quociente <= '0;
            Resto     <= '0;
            Overflow  <= 1'b0;
`ifdef DIVISOR_SEQ_DIVZERO_EN
            DivZero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (St) begin
                    acc      <= {1'b0, Dividendo};
                    dr       <= Divisor;
                    cnt      <= '0;
                    Overflow <= 1'b0;
`ifdef DIVISOR_SEQ_DIVZERO_EN
                    DivZero  <= (Divisor == '0);
`endif
                end
                CHK: if (chk_abort) begin
                    Overflow  <= ovf_set;
                    Quociente <= '0;
                    Resto     <= '0;
                end
                STEP: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Quociente <= acc_step[N-1:0];
                        Resto     <= acc_step[2*N-1:N];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential shift-subtract unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.
- Inverse companion of the team's shift-add multiplier.
- Same St/Idle/Done start-done handshake, so both blocks share one bench harness.
- One shift-compare-subtract step per clock; Moore-style status outputs.

Parameters:
- N, 4, divisor/quotient/remainder width; dividend is 2N bits.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- St  input  1  start request, sampled only in IDLE.
- Dividendo  input  2N  unsigned dividend, captured on the start edge.
- Divisor  input  N  unsigned divisor, captured on the start edge.
- Quociente  output  N  registered quotient.
- Resto  output  N  registered remainder.
- Overflow  output  1  quotient does not fit in N bits, or divisor zero.
- Idle  output  1  high while in IDLE.
- Done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset asserted (Reset=0), async: state=IDLE, Quociente=0, Resto=0, Overflow=0, Done=0, Idle=1, internal accumulator/counter=0.
- States: IDLE, CHK, STEP, DONE.
- IDLE:
  - Idle=1.
  - St=1 at an edge: ACC(2N+1 bits)={0,Dividendo}, latch Divisor into DR, cnt=0, Overflow cleared -> CHK.
  - Quociente/Resto keep their last values until the next result is written.
- CHK (1 cycle):
  - If DR==0 or ACC[2N-1:N] >= DR: Overflow=1, Quociente=0, Resto=0 -> DONE.
  - Else -> STEP.
- STEP (exactly N cycles), each edge:
  - Shift ACC left 1.
  - If shifted ACC[2N:N] >= DR: subtract DR from ACC[2N:N] and set ACC[0]=1.
  - cnt++.
  - When cnt reaches N-1 on that edge: write Quociente=ACC[N-1:0] and Resto=ACC[2N-1:N] from the updated value -> DONE.
- DONE (1 cycle): Done=1, Idle=0 -> IDLE unconditionally.
- Latency, with the St-sampling edge as edge 0:
  - Normal: Done high after edge N+1 (edge 5 for N=4).
  - Overflow: Done high after edge 1.
- Arithmetic:
  - Compare/subtract at N+1 bits.
  - Invariant at DONE (non-overflow): Dividendo == Quociente*DR + Resto, with Resto < DR.
- St outside IDLE: ignored. Dividendo/Divisor changes after the start edge have no effect.
- St held continuously high: back-to-back operations, one Idle cycle between Done and the next CHK.
- Reset mid-operation: immediate abort to the reset values above; no Done pulse.
- Idle and Done are never high together. Done is never high for 2 consecutive cycles.

Optional Feature:
- Macro: DIVISOR_SEQ_DIVZERO_EN.
- Defined:
  - Extra output DivZero (1 bit), reset 0.
  - DivZero=1 from CHK through the end of DONE only when DR==0; Overflow stays 0 in that case.
  - DivZero clears on the next start edge.
- Undefined:
  - No DivZero port.
  - DR==0 is reported through Overflow=1 as above.

Decomposition:
- Package divisor_seq_pkg holds:
  - State encoding constants (IDLE=2'd0, CHK=2'd1, STEP=2'd2, DONE=2'd3).
  - Default width constant N=4.
- One combinational sub-module, divisor_seq_subcmp:
  - Inputs: (N+1)-bit partial remainder and N-bit divisor.
  - Outputs: ge flag and difference.
- Controller FSM and ACC/cnt registers stay in the top.

Test Plan:
- Normal: Dividendo=135, Divisor=13, St pulse -> Done after edge 5, Quociente=10, Resto=5, Overflow=0, Idle low during edges 1-5.
- Overflow: Dividendo=160, Divisor=5 -> Done after edge 1, Overflow=1, Quociente=0, Resto=0.
- Zero divisor: Dividendo=7, Divisor=0 -> Overflow=1 (macro off); DivZero=1 and Overflow=0 (macro on).
- Boundary: Dividendo=239, Divisor=15 -> Quociente=15, Resto=14. Dividendo=0, Divisor=1 -> Quociente=0, Resto=0.
- Handshake:
  - St held high: results 135/13 then 100/7 -> second Done 7 cycles after first; second result Quociente=14, Resto=2.
  - St pulsed during STEP -> ignored.
- Reset mid-op: Reset=0 during STEP cycle 2 -> immediately Idle=1, outputs 0, no Done. After release, 200/13 -> Quociente=15, Resto=5.
- Exhaustive sweep of all non-overflow operand pairs checks the DONE invariant.
